// File: rtl/reconfig_pulse_timer.sv
// Reconfigurable pulse timer: counts P+1 cycles, then drives a max(L,1)-cycle pulse,
// either free-running or as a one-shot, with retrigger and synchronous abort.
`timescale 1ns/1ps
module reconfig_pulse_timer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PLW       = 4,
    parameter bit          RETRIGGER = 1'b1
) (
    input  logic             pulseClk,
    input  logic             rstN,
    input  logic             enable,
    input  logic             mode,
    input  logic             start,
    input  logic [WIDTH-1:0] timeAdj,
    input  logic [PLW-1:0]   pulseLen,
    output logic             pulseROut,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             doneOut
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_COUNT = 2'b01,
        S_PULSE = 2'b10
    } state_e;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [PLW-1:0]   PL_ONE  = PLW'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [PLW-1:0]   pcnt_q, pcnt_d;
    logic             pulse_q, pulse_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic in_run;
    assign in_run = (state_q == S_COUNT) || (state_q == S_PULSE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge pulseClk or negedge rstN) begin
        if (!rstN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Priority: abort, then retrigger, then the normal per-state transition.
    always_comb begin
        // NOTE: every target gets a default first, so no path through the
        // case leaves it unassigned and no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        pcnt_d  = pcnt_q;
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
        end else if (RETRIGGER && start && in_run) begin
            state_d = S_COUNT;
            cnt_d   = timeAdj;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d  = '0;
                    pcnt_d = '0;
                    if (!mode || start) begin
                        state_d = S_COUNT;
                        cnt_d   = timeAdj;
                    end
                end
                S_COUNT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        state_d = S_PULSE;
                        pcnt_d  = (pulseLen == '0) ? '0 : pulseLen - PL_ONE;
                    end
                end
                S_PULSE: begin
                    if (pcnt_q != '0) begin
                        pcnt_d = pcnt_q - PL_ONE;
                    end else if (!mode) begin
                        state_d = S_COUNT;
                        cnt_d   = timeAdj;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    pcnt_d  = '0;
                end
            endcase
        end
    end

    // Registered outputs follow the next state; done only on a natural one-shot end.
    always_comb begin
        pulse_d = (state_d == S_PULSE);
        busy_d  = (state_d != S_IDLE);
        done_d  = enable && (state_q == S_PULSE) && (state_d == S_IDLE);
    end

    assign pulseROut = pulse_q;
    assign busy      = busy_q;
    assign count     = cnt_q;
    assign doneOut   = done_q;

endmodule

// File: tb/tb_reconfig_pulse_timer.sv
// Self-checking bench: two timers (retrigger on/off) share stimulus and are
// compared every edge against a timeline model built from load edge, P and L.
`timescale 1ns/1ps
module tb_reconfig_pulse_timer;

    localparam int W  = 8;
    localparam int PL = 4;

    logic          pulseClk = 1'b0;
    logic          rstN     = 1'b0;
    logic          enable   = 1'b0;
    logic          mode     = 1'b0;
    logic          start    = 1'b0;
    logic [W-1:0]  timeAdj  = '0;
    logic [PL-1:0] pulseLen = '0;

    logic          pulse_rt, busy_rt, done_rt;
    logic [W-1:0]  count_rt;
    logic          pulse_nr, busy_nr, done_nr;
    logic [W-1:0]  count_nr;

    always #5 pulseClk = ~pulseClk;

    reconfig_pulse_timer #(.WIDTH(W), .PLW(PL), .RETRIGGER(1'b1)) dut_rt (
        .pulseClk (pulseClk), .rstN (rstN), .enable (enable), .mode (mode),
        .start (start), .timeAdj (timeAdj), .pulseLen (pulseLen),
        .pulseROut (pulse_rt), .busy (busy_rt), .count (count_rt), .doneOut (done_rt)
    );

    reconfig_pulse_timer #(.WIDTH(W), .PLW(PL), .RETRIGGER(1'b0)) dut_nr (
        .pulseClk (pulseClk), .rstN (rstN), .enable (enable), .mode (mode),
        .start (start), .timeAdj (timeAdj), .pulseLen (pulseLen),
        .pulseROut (pulse_nr), .busy (busy_nr), .count (count_nr), .doneOut (done_nr)
    );

    int checks = 0;
    int errors = 0;
    int n      = 0;   // index of the last rising edge

    // Timeline model; index 0 retriggers, index 1 does not.
    // A run is described by its load edge k, count value P and pulse length l.
    bit m_active [2];
    int m_k      [2];
    int m_p      [2];
    int m_l      [2];
    bit m_done   [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit exp_pulse(input int i);
        return m_active[i] && (n >= m_k[i] + m_p[i] + 1);
    endfunction

    function automatic int exp_count(input int i);
        return (m_active[i] && n <= m_k[i] + m_p[i]) ? m_p[i] - (n - m_k[i]) : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0;
            m_done[i]   = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (!rstN || !enable) begin
                m_active[i] = 1'b0;
            end else if (m_active[i] && i == 0 && start) begin
                m_k[i] = n;
                m_p[i] = int'(timeAdj);
            end else if (!m_active[i]) begin
                if (!mode || start) begin
                    m_active[i] = 1'b1;
                    m_k[i]      = n;
                    m_p[i]      = int'(timeAdj);
                end
            end else if (n == m_k[i] + m_p[i] + 1) begin
                m_l[i] = (pulseLen == '0) ? 1 : int'(pulseLen);
            end else if (n == m_k[i] + m_p[i] + 1 + m_l[i]) begin
                if (!mode) begin
                    m_k[i] = n;
                    m_p[i] = int'(timeAdj);
                end else begin
                    m_active[i] = 1'b0;
                    m_done[i]   = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("rt.pulse", 32'(pulse_rt), 32'(exp_pulse(0)));
        chk("rt.busy",  32'(busy_rt),  32'(m_active[0]));
        chk("rt.count", 32'(count_rt), 32'(exp_count(0)));
        chk("rt.done",  32'(done_rt),  32'(m_done[0]));
        chk("nr.pulse", 32'(pulse_nr), 32'(exp_pulse(1)));
        chk("nr.busy",  32'(busy_nr),  32'(m_active[1]));
        chk("nr.count", 32'(count_nr), 32'(exp_count(1)));
        chk("nr.done",  32'(done_nr),  32'(m_done[1]));
    endtask

    task automatic step();
        @(posedge pulseClk);
        n++;
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic run_until_pulse(input string tag, input int budget);
        int used;
        used = 0;
        while (pulse_rt !== 1'b1 && used < budget) begin
            step();
            used++;
        end
        chk(tag, 32'(pulse_rt), 32'd1);
    endtask

    initial begin
        int en_edge, ks, hi, cyc, guard;

        for (int i = 0; i < 2; i++) begin
            m_active[i] = 1'b0; m_k[i] = 0; m_p[i] = 0; m_l[i] = 1; m_done[i] = 1'b0;
        end

        // Reset held across edges: everything idle and zero.
        run(2);

        // Periodic P=5, L=3.
        timeAdj  = 8'd5;
        pulseLen = 4'd3;
        #2 rstN  = 1'b1;
        enable   = 1'b1;
        en_edge  = n + 1;
        run_until_pulse("periodic.first_rise_seen", 20);
        // Counting the enable-sampling (load) edge as the first, the rise is edge P+2.
        chk("periodic.first_rise_latency", 32'(n - en_edge), 32'd6);
        hi = 1;
        for (int c = 0; c < 8; c++) begin
            step();
            hi += int'(pulse_rt);
        end
        chk("periodic.high_cycles_per_9", 32'(hi), 32'd3);
        step();
        chk("periodic.period_9", 32'(pulse_rt), 32'd1);

        // P=0, L=0 picked up at the next reload: 2-cycle period.
        timeAdj  = 8'd0;
        pulseLen = 4'd0;
        run(16);

        // Asynchronous reset while the pulse is high.
        timeAdj  = 8'd3;
        pulseLen = 4'd2;
        run(12);
        run_until_pulse("rst_mid_pulse.seen", 20);
        #3 rstN = 1'b0;
        #1;
        model_reset();
        chk("rst_async.pulse", 32'(pulse_rt), 32'd0);
        chk("rst_async.busy",  32'(busy_rt),  32'd0);
        chk("rst_async.count", 32'(count_rt), 32'd0);
        run(2);
        rstN   = 1'b1;
        enable = 1'b0;
        run(3);

        // One-shot P=4, L=2.
        mode     = 1'b1;
        enable   = 1'b1;
        timeAdj  = 8'd4;
        pulseLen = 4'd2;
        run(2);
        start = 1'b1;
        step();
        start = 1'b0;
        ks = n;
        for (int c = 0; c < 12; c++) begin
            step();
            if (n == ks + 5) chk("oneshot.high_first", 32'(pulse_rt), 32'd1);
            if (n == ks + 6) chk("oneshot.high_last",  32'(pulse_rt), 32'd1);
            if (n == ks + 7) begin
                chk("oneshot.done", 32'(done_rt), 32'd1);
                chk("oneshot.idle", 32'(busy_rt), 32'd0);
            end
        end

        // Retrigger at count=2 with P=6.
        timeAdj = 8'd6;
        start   = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (count_rt !== 8'd2 && guard < 10) begin
            step();
            guard++;
        end
        chk("retrig.reached_2", 32'(count_rt), 32'd2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("retrig.reload",    32'(count_rt), 32'd6);
        chk("noretrig.ignored", 32'(count_nr), 32'd1);
        run(20);

        // Abort mid-PULSE in periodic mode.
        mode     = 1'b0;
        timeAdj  = 8'd2;
        pulseLen = 4'd4;
        run_until_pulse("abort.pulse_seen", 20);
        step();
        enable = 1'b0;
        step();
        chk("abort.pulse_low", 32'(pulse_rt), 32'd0);
        chk("abort.no_done",   32'(done_rt),  32'd0);
        run(2);

        // timeAdj changed mid-COUNT: current period keeps 5, next uses 2.
        enable   = 1'b1;
        timeAdj  = 8'd5;
        pulseLen = 4'd1;
        run(3);
        timeAdj = 8'd2;
        run(20);

        // Extremes: P=255, L=15.
        enable = 1'b0;
        step();
        timeAdj  = 8'd255;
        pulseLen = 4'd15;
        enable   = 1'b1;
        step();
        cyc   = 0;
        guard = 0;
        while (busy_rt === 1'b1 && pulse_rt === 1'b0 && guard < 400) begin
            cyc++;
            guard++;
            step();
        end
        chk("extreme.count_cycles", 32'(cyc), 32'd256);
        hi    = 0;
        guard = 0;
        while (pulse_rt === 1'b1 && guard < 40) begin
            hi++;
            guard++;
            step();
        end
        chk("extreme.high_cycles", 32'(hi), 32'd15);
        run(5);

        // Randomised traffic.
        for (int c = 0; c < 1500; c++) begin
            enable   = ($urandom_range(0, 31) != 0);
            start    = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 47) == 0) mode = ~mode;
            timeAdj  = W'($urandom_range(0, 7));
            pulseLen = PL'($urandom_range(0, 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reconfig_pulse_timer.md
# reconfig_pulse_timer

Parametrised, reconfigurable pulse timer. It is the multi-mode successor of the team's 8-bit reconfigurable timer. It generates a programmable-width pulse after a programmable count, in either free-running (periodic) or one-shot mode, with retrigger and synchronous abort. It sits in the timing/pulse-generation layer and drives downstream pulse consumers from a single pulse clock.

## Interface
Parameters:
- WIDTH, 8: width of the period counter and `timeAdj`.
- PLW, 4: width of `pulseLen` and of the pulse-width counter.
- RETRIGGER, 1: when 1, `start` while busy restarts the count; when 0, `start` while busy is ignored.

Ports:
- pulseClk  in  1  clock; all state updates on the rising edge.
- rstN  in  1  reset; **one clock; reset is asynchronous and active-low**.
- enable  in  1  timer enable; low forces IDLE at the next edge.
- mode  in  1  0 = periodic (free-running), 1 = one-shot.
- start  in  1  one-shot arm / retrigger; single-cycle strobe.
- timeAdj  in  WIDTH  count value P, sampled on every load.
- pulseLen  in  PLW  pulse width L in cycles, sampled on entry to PULSE; 0 is treated as 1.
- pulseROut  out  1  timer pulse, registered.
- busy  out  1  high when state ≠ IDLE, registered.
- count  out  WIDTH  current period-counter value.
- doneOut  out  1  single-cycle strobe at the end of a one-shot pulse.

## Operation
- States: IDLE, COUNT, PULSE. Encoding is 2 bits; the unused code goes to IDLE at the next edge.
- Reset (rstN=0, asynchronous): state=IDLE, counter=0, pulse counter=0, pulseROut=0, busy=0, doneOut=0. Release is synchronous to pulseClk.
- **IDLE** (pulseROut=0, count=0):
  - enable=1 and mode=0: load counter←timeAdj, then go to COUNT.
  - enable=1, mode=1 and start=1: load counter←timeAdj, then go to COUNT.
  - Otherwise stay in IDLE.
- **COUNT**:
  - counter>0: decrement by 1.
  - counter==0: go to PULSE, load the pulse counter with max(pulseLen,1)−1, and set pulseROut=1.
- **PULSE** (pulseROut=1):
  - Pulse counter >0: decrement by 1.
  - Pulse counter ==0, mode=0 and enable=1: reload counter←timeAdj, clear pulseROut, go to COUNT.
  - Pulse counter ==0, mode=1: clear pulseROut, go to IDLE, and pulse doneOut=1 for one cycle.
- **Abort**: enable=0 in any state → IDLE at the next edge; pulseROut=0, counter=0, no doneOut. A pulse in progress is truncated.
- **Retrigger** (RETRIGGER=1): start=1 in COUNT or PULSE (either mode) reloads counter←timeAdj, clears pulseROut and goes to COUNT. With RETRIGGER=0, start is ignored outside IDLE.
- **Priority** at each edge: enable=0 > start retrigger > normal transition.
- **Mode changes** take effect only at the PULSE-end decision or in IDLE. A changed timeAdj takes effect only at the next load, so there is no mid-count update.
- **Arithmetic**: counters are unsigned and never wrap; the decrement happens only when the counter is >0.

## Timing
- Load-to-pulse latency: if the load edge is k, COUNT occupies edges k..k+P (P+1 cycles), and pulseROut rises at edge k+P+1.
- The pulse stays high for exactly max(L,1) cycles.
- Periodic steady state: period is P+1+max(L,1) cycles and high time is max(L,1) cycles.
  - Example: P=0, L=1 gives a 2-cycle period at 50% duty.
- Periodic start: the first load happens at the first edge where enable=1 in IDLE. The first pulse rises P+2 edges after enable is first sampled high.
- One-shot: start sampled at edge k gives pulseROut high over edges k+P+1 .. k+P+L. doneOut is high for the cycle after the last high cycle, coincident with the return to IDLE.
- busy rises with the load edge and falls with the IDLE entry. count reflects the counter after each edge.

## Test plan
- Reset mid-pulse: periodic, P=3, L=2; assert rstN=0 while pulseROut=1 → pulseROut, busy and count are 0 immediately (asynchronous), and state stays IDLE until enable is sampled after release.
- Periodic: enable=1, P=5, L=3 → pulseROut high 3 cycles and low 6 cycles, period 9, first rise 7 edges after enable is sampled; P=0, L=0 → alternating 1/0 pattern.
- One-shot: mode=1, P=4, L=2, start at edge 10 → pulseROut high at edges 15–16, doneOut=1 at edge 17, busy low from edge 17, and no further pulses.
- Retrigger: one-shot with P=6, restart at count=2 → counter reloads to 6 and the pulse is delayed by 5 cycles. Same stimulus with RETRIGGER=0 → the start is ignored and timing is unchanged.
- Abort and reconfigure: drop enable mid-PULSE → pulseROut falls next edge with no doneOut. Change timeAdj from 5 to 2 mid-COUNT → the current period is unchanged and the next period uses 2.
- Extremes: WIDTH=8, P=255, L=15 → 256 COUNT cycles followed by 15 high cycles, and the counter never underflows.
